// File: rtl/ienc_pkg.sv
// Instruction encoder shared definitions: op enum, MIPS opcode/funct fields, loader FSM states.
// Latency: n/a (types, constants and pure field-packing helpers only).
// Backpressure: n/a.
package ienc_pkg;

    // Symbolic operations accepted by the loader; values 30 and 31 are deliberately unassigned
    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLL  = 5'd7,
        OP_SRL  = 5'd8,  OP_JR   = 5'd9,  OP_MUL  = 5'd10, OP_ADDI = 5'd11,
        OP_SLTI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_XORI = 5'd15,
        OP_LB   = 5'd16, OP_LH   = 5'd17, OP_LW   = 5'd18, OP_SB   = 5'd19,
        OP_SH   = 5'd20, OP_SW   = 5'd21, OP_BEQ  = 5'd22, OP_BNE  = 5'd23,
        OP_BLEZ = 5'd24, OP_BGTZ = 5'd25, OP_BLTZ = 5'd26, OP_BGEZ = 5'd27,
        OP_J    = 5'd28, OP_JAL  = 5'd29
    } op_e;

    localparam logic [5:0] OPC_RTYPE  = 6'h00;
    localparam logic [5:0] OPC_REGIMM = 6'h01;
    localparam logic [5:0] OPC_J      = 6'h02;
    localparam logic [5:0] OPC_JAL    = 6'h03;
    localparam logic [5:0] OPC_BEQ    = 6'h04;
    localparam logic [5:0] OPC_BNE    = 6'h05;
    localparam logic [5:0] OPC_BLEZ   = 6'h06;
    localparam logic [5:0] OPC_BGTZ   = 6'h07;
    localparam logic [5:0] OPC_ADDI   = 6'h08;
    localparam logic [5:0] OPC_SLTI   = 6'h0A;
    localparam logic [5:0] OPC_ANDI   = 6'h0C;
    localparam logic [5:0] OPC_ORI    = 6'h0D;
    localparam logic [5:0] OPC_XORI   = 6'h0E;
    localparam logic [5:0] OPC_MUL    = 6'h1C;
    localparam logic [5:0] OPC_LB     = 6'h20;
    localparam logic [5:0] OPC_LH     = 6'h21;
    localparam logic [5:0] OPC_LW     = 6'h23;
    localparam logic [5:0] OPC_SB     = 6'h28;
    localparam logic [5:0] OPC_SH     = 6'h29;
    localparam logic [5:0] OPC_SW     = 6'h2B;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_MUL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // REGIMM branches select the condition through the rt field
    localparam logic [4:0] REGIMM_BLTZ = 5'd0;
    localparam logic [4:0] REGIMM_BGEZ = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    function automatic logic [31:0] encR(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] shamt, input logic [5:0] funct);
        return {opc, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Maps a symbolic op plus register/immediate/target fields to a 32-bit MIPS word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; flags ops outside the table as illegal and outputs a zero word.
module instr_encode_comb
    import ienc_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Field packing per op; immediates are inserted verbatim without sign or range checks
    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADD);
            OP_SUB:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUB);
            OP_AND:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_AND);
            OP_OR:   word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_OR);
            OP_XOR:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_XOR);
            OP_NOR:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_NOR);
            OP_SLT:  word = encR(OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT);
            OP_SLL:  word = encR(OPC_RTYPE, 5'd0, rt, rd, imm[4:0], FUNCT_SLL);
            OP_SRL:  word = encR(OPC_RTYPE, 5'd0, rt, rd, imm[4:0], FUNCT_SRL);
            OP_JR:   word = encR(OPC_RTYPE, rs, 5'd0, 5'd0, 5'd0, FUNCT_JR);
            OP_MUL:  word = encR(OPC_MUL, rs, rt, rd, 5'd0, FUNCT_MUL);
            OP_ADDI: word = encI(OPC_ADDI, rs, rt, imm);
            OP_SLTI: word = encI(OPC_SLTI, rs, rt, imm);
            OP_ANDI: word = encI(OPC_ANDI, rs, rt, imm);
            OP_ORI:  word = encI(OPC_ORI, rs, rt, imm);
            OP_XORI: word = encI(OPC_XORI, rs, rt, imm);
            OP_LB:   word = encI(OPC_LB, rs, rt, imm);
            OP_LH:   word = encI(OPC_LH, rs, rt, imm);
            OP_LW:   word = encI(OPC_LW, rs, rt, imm);
            OP_SB:   word = encI(OPC_SB, rs, rt, imm);
            OP_SH:   word = encI(OPC_SH, rs, rt, imm);
            OP_SW:   word = encI(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = encI(OPC_BEQ, rs, rt, imm);
            OP_BNE:  word = encI(OPC_BNE, rs, rt, imm);
            OP_BLEZ: word = encI(OPC_BLEZ, rs, 5'd0, imm);
            OP_BGTZ: word = encI(OPC_BGTZ, rs, 5'd0, imm);
            OP_BLTZ: word = encI(OPC_REGIMM, rs, REGIMM_BLTZ, imm);
            OP_BGEZ: word = encI(OPC_REGIMM, rs, REGIMM_BGEZ, imm);
            OP_J:    word = {OPC_J, target};
            OP_JAL:  word = {OPC_JAL, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests and writes them to consecutive instruction-memory words.
// Latency: accept in cycle N gives the memory write in cycle N+1; one word per two cycles.
// Backpressure: InReady is high only in LOAD; Optional IENC_CHECKSUM_EN adds a per-session XOR Checksum.
module instr_encoder_loader
    import ienc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              InValid,
    output logic              InReady,
    input  logic [4:0]        InOp,
    input  logic [4:0]        InRs,
    input  logic [4:0]        InRt,
    input  logic [4:0]        InRd,
    input  logic [15:0]       InImm,
    input  logic [25:0]       InTarget,
    input  logic              InLast,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWrData,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [ADDR_W:0]   Count
`ifdef IENC_CHECKSUM_EN
    ,
    output logic [31:0]       Checksum
`endif
);

    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CountOne = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    state_e            state;
    state_e            stateNxt;
    logic [ADDR_W-1:0] addrPtr;
    logic              lastReg;
    logic [31:0]       encWord;
    logic              encIllegal;
    logic              accept;
    logic              reqBad;
    logic              startTake;

    instr_encode_comb uEncode (
        .op      (InOp),
        .rs      (InRs),
        .rt      (InRt),
        .rd      (InRd),
        .imm     (InImm),
        .target  (InTarget),
        .word    (encWord),
        .illegal (encIllegal)
    );

    // State register; reset forces IDLE so a pending write strobe drops at once
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state and Moore outputs; Start is only honoured while InReady is low
    always_comb begin
        stateNxt  = state;
        InReady   = 1'b0;
        MemWrEn   = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        accept    = 1'b0;
        reqBad    = 1'b0;
        startTake = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    startTake = 1'b1;
                    stateNxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (InValid) begin
                    accept   = 1'b1;
                    reqBad   = encIllegal || (Count == DepthCnt);
                    stateNxt = reqBad ? ST_ERROR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                MemWrEn  = 1'b1;
                Busy     = 1'b1;
                stateNxt = lastReg ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                Done = 1'b1;
                if (Start) begin
                    startTake = 1'b1;
                    stateNxt  = ST_LOAD;
                end else begin
                    stateNxt = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (Start) begin
                    startTake = 1'b1;
                    stateNxt  = ST_LOAD;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    // Datapath: capture the encoded word on accept, advance pointer/count after each write
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addrPtr   <= '0;
            MemAddr   <= '0;
            MemWrData <= 32'h0;
            lastReg   <= 1'b0;
            Count     <= '0;
            Error     <= 1'b0;
        end else begin
            if (startTake) begin
                addrPtr <= BaseAddr;
                Count   <= '0;
                Error   <= 1'b0;
            end
            if (accept) begin
                if (reqBad) begin
                    Error <= 1'b1;
                end else begin
                    MemWrData <= encWord;
                    MemAddr   <= addrPtr;
                    lastReg   <= InLast;
                end
            end
            if (state == ST_WRITE) begin
                Count   <= Count + CountOne;
                addrPtr <= addrPtr + AddrOne;
            end
        end
    end

`ifdef IENC_CHECKSUM_EN
    // Running XOR of every word actually written in the current session
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Checksum <= 32'h0;
        end else if (startTake) begin
            Checksum <= 32'h0;
        end else if (state == ST_WRITE) begin
            Checksum <= Checksum ^ MemWrData;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
    import ienc_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  BaseAddr = 8'h0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [4:0]  InOp = 5'd0;
    logic [4:0]  InRs = 5'd0;
    logic [4:0]  InRt = 5'd0;
    logic [4:0]  InRd = 5'd0;
    logic [15:0] InImm = 16'h0;
    logic [25:0] InTarget = 26'h0;
    logic        InLast = 1'b0;
    logic        MemWrEn;
    logic [7:0]  MemAddr;
    logic [31:0] MemWrData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [8:0]  Count;
`ifdef IENC_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    int nChecks = 0;
    int nBad = 0;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .BaseAddr(BaseAddr),
        .InValid(InValid), .InReady(InReady), .InOp(InOp), .InRs(InRs), .InRt(InRt),
        .InRd(InRd), .InImm(InImm), .InTarget(InTarget), .InLast(InLast),
        .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .Busy(Busy), .Done(Done), .Error(Error), .Count(Count)
`ifdef IENC_CHECKSUM_EN
        , .Checksum(Checksum)
`endif
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic doStart(input logic [7:0] base);
        @(negedge Clk);
        Start = 1'b1;
        BaseAddr = base;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Waits (bounded) for InReady, presents one request for one cycle, and snapshots the write cycle
    task automatic issue(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last, output bit ok, output logic w,
                         output logic [7:0] a, output logic [31:0] d);
        ok = 1'b0;
        w = 1'b0;
        a = 8'h0;
        d = 32'h0;
        for (int i = 0; i < 10; i++) begin
            if (InReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        if (ok) begin
            InValid = 1'b1; InOp = op; InRs = rs; InRt = rt; InRd = rd;
            InImm = imm; InTarget = tgt; InLast = last;
            @(negedge Clk);
            InValid = 1'b0;
            InLast = 1'b0;
            w = MemWrEn;
            a = MemAddr;
            d = MemWrData;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        nChecks++; if (InReady !== 1'b0) begin nBad++; $display("FAIL rst_inready got=%b exp=0", InReady); end
        nChecks++; if (MemWrEn !== 1'b0) begin nBad++; $display("FAIL rst_wren got=%b exp=0", MemWrEn); end
        nChecks++; if (Busy !== 1'b0) begin nBad++; $display("FAIL rst_busy got=%b exp=0", Busy); end
        nChecks++; if (Done !== 1'b0) begin nBad++; $display("FAIL rst_done got=%b exp=0", Done); end
        nChecks++; if (Error !== 1'b0) begin nBad++; $display("FAIL rst_error got=%b exp=0", Error); end
        nChecks++; if (MemAddr !== 8'h0) begin nBad++; $display("FAIL rst_addr got=%h exp=00", MemAddr); end
        nChecks++; if (MemWrData !== 32'h0) begin nBad++; $display("FAIL rst_data got=%h exp=0", MemWrData); end
        nChecks++; if (Count !== 9'd0) begin nBad++; $display("FAIL rst_count got=%0d exp=0", Count); end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_ignore();
        InValid = 1'b1;
        InOp = OP_ADD;
        repeat (2) begin
            @(negedge Clk);
            nChecks++; if (InReady !== 1'b0 || MemWrEn !== 1'b0 || Busy !== 1'b0) begin nBad++; $display("FAIL idle_invalid got rdy=%b wr=%b busy=%b exp all 0", InReady, MemWrEn, Busy); end
        end
        InValid = 1'b0;
    endtask

    task automatic test_single();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h10);
        nChecks++; if (InReady !== 1'b1 || Busy !== 1'b1) begin nBad++; $display("FAIL t1_load got rdy=%b busy=%b exp 1 1", InReady, Busy); end
        issue(OP_ADDI, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b1, ok, w, a, d);
        nChecks++; if (!ok) begin nBad++; $display("FAIL t1_ready timeout waiting for InReady"); end
        nChecks++; if (w !== 1'b1) begin nBad++; $display("FAIL t1_wren got=%b exp=1", w); end
        nChecks++; if (a !== 8'h10) begin nBad++; $display("FAIL t1_addr got=%h exp=10", a); end
        nChecks++; if (d !== 32'h20220005) begin nBad++; $display("FAIL t1_data got=%h exp=20220005", d); end
        nChecks++; if (InReady !== 1'b0 || Done !== 1'b0) begin nBad++; $display("FAIL t1_write_state got rdy=%b done=%b exp 0 0", InReady, Done); end
        @(negedge Clk);
        nChecks++; if (Done !== 1'b1 || MemWrEn !== 1'b0) begin nBad++; $display("FAIL t1_done got done=%b wr=%b exp 1 0", Done, MemWrEn); end
        nChecks++; if (Count !== 9'd1) begin nBad++; $display("FAIL t1_count got=%0d exp=1", Count); end
        @(negedge Clk);
        nChecks++; if (Done !== 1'b0 || Busy !== 1'b0) begin nBad++; $display("FAIL t1_idle got done=%b busy=%b exp 0 0", Done, Busy); end
    endtask

    task automatic test_multi();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h20);
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h20 || d !== 32'h00221820) begin nBad++; $display("FAIL t2_add got ok=%b wr=%b addr=%h data=%h exp 1 1 20 00221820", ok, w, a, d); end
        // rs and the upper immediate bits must not leak into the shift encoding
        issue(OP_SLL, 5'd7, 5'd2, 5'd4, 16'hFFE3, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h21 || d !== 32'h000220C0) begin nBad++; $display("FAIL t2_sll got ok=%b wr=%b addr=%h data=%h exp 1 1 21 000220C0", ok, w, a, d); end
        nChecks++; if (Count !== 9'd1) begin nBad++; $display("FAIL t2_count_mid got=%0d exp=1", Count); end
        issue(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b1, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h22 || d !== 32'h08000040) begin nBad++; $display("FAIL t2_j got ok=%b wr=%b addr=%h data=%h exp 1 1 22 08000040", ok, w, a, d); end
        @(negedge Clk);
        nChecks++; if (Done !== 1'b1 || Count !== 9'd3) begin nBad++; $display("FAIL t2_done got done=%b count=%0d exp 1 3", Done, Count); end
`ifdef IENC_CHECKSUM_EN
        nChecks++; if (Checksum !== 32'h082038A0) begin nBad++; $display("FAIL t2_checksum got=%h exp=082038A0", Checksum); end
`endif
    endtask

    task automatic test_branches();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h30);
`ifdef IENC_CHECKSUM_EN
        nChecks++; if (Checksum !== 32'h0) begin nBad++; $display("FAIL t3_checksum_clear got=%h exp=0", Checksum); end
`endif
        issue(OP_BGEZ, 5'd5, 5'd9, 5'd0, 16'hFFFE, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h30 || d !== 32'h04A1FFFE) begin nBad++; $display("FAIL t3_bgez got ok=%b wr=%b addr=%h data=%h exp 1 1 30 04A1FFFE", ok, w, a, d); end
        issue(OP_BLTZ, 5'd5, 5'd9, 5'd0, 16'h0002, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h31 || d !== 32'h04A00002) begin nBad++; $display("FAIL t3_bltz got ok=%b wr=%b addr=%h data=%h exp 1 1 31 04A00002", ok, w, a, d); end
        issue(OP_BGTZ, 5'd5, 5'd9, 5'd0, 16'h0001, 26'h0, 1'b1, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h32 || d !== 32'h1CA00001) begin nBad++; $display("FAIL t3_bgtz got ok=%b wr=%b addr=%h data=%h exp 1 1 32 1CA00001", ok, w, a, d); end
        @(negedge Clk);
        nChecks++; if (Done !== 1'b1) begin nBad++; $display("FAIL t3_done got=%b exp=1", Done); end
    endtask

    task automatic test_misc();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h50);
        // a second Start while loading must not move the address pointer
        Start = 1'b1;
        BaseAddr = 8'h99;
        @(negedge Clk);
        Start = 1'b0;
        nChecks++; if (InReady !== 1'b1 || Busy !== 1'b1) begin nBad++; $display("FAIL t_busy_start got rdy=%b busy=%b exp 1 1", InReady, Busy); end
        issue(OP_JR, 5'd31, 5'd6, 5'd7, 16'h00FF, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h50 || d !== 32'h03E00008) begin nBad++; $display("FAIL t_jr got ok=%b wr=%b addr=%h data=%h exp 1 1 50 03E00008", ok, w, a, d); end
        issue(OP_MUL, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h51 || d !== 32'h70221802) begin nBad++; $display("FAIL t_mul got ok=%b wr=%b addr=%h data=%h exp 1 1 51 70221802", ok, w, a, d); end
        issue(OP_SW, 5'd29, 5'd31, 5'd0, 16'h0010, 26'h0, 1'b1, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h52 || d !== 32'hAFBF0010) begin nBad++; $display("FAIL t_sw got ok=%b wr=%b addr=%h data=%h exp 1 1 52 AFBF0010", ok, w, a, d); end
        @(negedge Clk);
        nChecks++; if (Done !== 1'b1 || Count !== 9'd3) begin nBad++; $display("FAIL t_misc_done got done=%b count=%0d exp 1 3", Done, Count); end
    endtask

    task automatic test_illegal();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h40);
        issue(5'd31, 5'd1, 5'd2, 5'd3, 16'h1111, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b0) begin nBad++; $display("FAIL t4_nowrite got ok=%b wr=%b exp 1 0", ok, w); end
        nChecks++; if (Error !== 1'b1 || InReady !== 1'b0 || Done !== 1'b0) begin nBad++; $display("FAIL t4_error got err=%b rdy=%b done=%b exp 1 0 0", Error, InReady, Done); end
        @(negedge Clk);
        nChecks++; if (Error !== 1'b1 || MemWrEn !== 1'b0 || Busy !== 1'b0) begin nBad++; $display("FAIL t4_sticky got err=%b wr=%b busy=%b exp 1 0 0", Error, MemWrEn, Busy); end
        doStart(8'h44);
        nChecks++; if (Error !== 1'b0 || InReady !== 1'b1 || Count !== 9'd0) begin nBad++; $display("FAIL t4_restart got err=%b rdy=%b count=%0d exp 0 1 0", Error, InReady, Count); end
        issue(OP_ADDI, 5'd0, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1 || a !== 8'h44 || d !== 32'h20001234) begin nBad++; $display("FAIL t4_after got ok=%b wr=%b addr=%h data=%h exp 1 1 44 20001234", ok, w, a, d); end
        @(negedge Clk);
    endtask

    task automatic test_overflow();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        logic [7:0] expA;
        doStart(8'hFE);
        for (int i = 0; i < 4; i++) begin
            issue(OP_ORI, 5'd1, 5'd2, 5'd0, 16'h00A0 + 16'(i), 26'h0, 1'b0, ok, w, a, d);
            expA = 8'hFE + 8'(i);
            nChecks++; if (!ok || w !== 1'b1 || a !== expA || d !== (32'h342200A0 + 32'(i))) begin nBad++; $display("FAIL t5_write%0d got ok=%b wr=%b addr=%h data=%h exp 1 1 %h %h", i, ok, w, a, d, expA, 32'h342200A0 + 32'(i)); end
        end
        issue(OP_ORI, 5'd1, 5'd2, 5'd0, 16'h00FF, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b0) begin nBad++; $display("FAIL t5_fifth got ok=%b wr=%b exp 1 0", ok, w); end
        nChecks++; if (Error !== 1'b1 || Count !== 9'd4) begin nBad++; $display("FAIL t5_error got err=%b count=%0d exp 1 4", Error, Count); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic w; logic [7:0] a; logic [31:0] d;
        doStart(8'h60);
        issue(OP_ADDI, 5'd3, 5'd4, 5'd0, 16'h0007, 26'h0, 1'b0, ok, w, a, d);
        nChecks++; if (!ok || w !== 1'b1) begin nBad++; $display("FAIL t5_prewrite got ok=%b wr=%b exp 1 1", ok, w); end
        #1 Rst_n = 1'b0;
        #1;
        nChecks++; if (MemWrEn !== 1'b0 || Busy !== 1'b0 || MemAddr !== 8'h0) begin nBad++; $display("FAIL t5_async_drop got wr=%b busy=%b addr=%h exp 0 0 00", MemWrEn, Busy, MemAddr); end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        nChecks++; if (InReady !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || Count !== 9'd0) begin nBad++; $display("FAIL t5_idle_after got rdy=%b busy=%b done=%b count=%0d exp 0 0 0 0", InReady, Busy, Done, Count); end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_single();
        test_multi();
        test_branches();
        test_misc();
        test_illegal();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
